llc_mem_responder: RTL and testbench
====================================

Name: llc_mem_responder

Overview:
- Memory-side endpoint of the LLC-to-memory request channel.
- Accepts whole-line read and write requests (llc_mem_req) issued by the LLC request-processing logic, e.g. flush writebacks and fill reads.
- Serializes each request into word-wide beats on a simple single-outstanding memory port.
- For reads, assembles the beats and returns the full line on llc_mem_rsp. Writes produce no LLC response.

Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, at least 2.
- WORD_BITS, 64, memory word width; multiple of 8.
- LINE_ADDR_BITS, 27, width of the line address.
- HPROT_BITS, 2, protection attribute width.
- Derived localparams:
  - BEAT_BITS = log2(WORDS_PER_LINE)
  - OFF_BITS = log2(WORD_BITS/8)
  - ADDR_BITS = LINE_ADDR_BITS + BEAT_BITS + OFF_BITS

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- llc_mem_req_valid  in  1  LLC request valid.
- llc_mem_req_ready  out  1  responder can accept a request.
- llc_mem_req_hwrite  in  1  1 = write line, 0 = read line.
- llc_mem_req_addr  in  LINE_ADDR_BITS  line address.
- llc_mem_req_hprot  in  HPROT_BITS  protection attribute.
- llc_mem_req_line  in  WORDS_PER_LINE*WORD_BITS  write data; word 0 in the LSBs.
- llc_mem_rsp_valid  out  1  read line valid.
- llc_mem_rsp_ready  in  1  LLC accepts the read line.
- llc_mem_rsp_line  out  WORDS_PER_LINE*WORD_BITS  read data; word 0 in the LSBs.
- mem_valid  out  1  memory beat request valid.
- mem_ready  in  1  memory accepts the beat.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_BITS  byte address of the beat.
- mem_wdata  out  WORD_BITS  write word.
- mem_hprot  out  HPROT_BITS  copy of the captured hprot.
- mem_rvalid  in  1  read data valid; one cycle per read beat.
- mem_rdata  in  WORD_BITS  read word.

Behaviour:
- Reset values: all outputs 0, state IDLE, beat counter 0, line buffer 0. Reset applies mid-operation too: the in-flight request is aborted and nothing is sent to the LLC.
- States: IDLE, WR_BEAT, RD_BEAT, RD_WAIT, RSP.
- IDLE:
  - llc_mem_req_ready = 1 (asserted only in IDLE).
  - On valid&&ready: capture addr, hprot, line and hwrite; clear the beat counter.
  - Next state is WR_BEAT if hwrite = 1, otherwise RD_BEAT.
- Beat addressing: mem_addr = {captured addr, beat, OFF_BITS'b0}.
  - mem_hprot is driven from the capture register while mem_valid = 1, and is 0 otherwise.
- WR_BEAT:
  - Drive mem_valid = 1, mem_we = 1, mem_wdata = captured word[beat].
  - On mem_ready: beat increments. On the last beat (beat = WORDS_PER_LINE-1), go to IDLE with no LLC response.
  - Outputs are held stable while mem_ready = 0.
- RD_BEAT:
  - Drive mem_valid = 1, mem_we = 0.
  - On mem_ready, go to RD_WAIT. mem_valid must deassert the following cycle, so at most one beat is outstanding.
- RD_WAIT:
  - On mem_rvalid: store mem_rdata into line word[beat].
  - If this was the last beat, go to RSP; otherwise increment beat and go to RD_BEAT.
  - mem_rvalid in any other state is ignored.
  - mem_rvalid in the same cycle as the mem_ready handshake is not possible, because the transition to RD_WAIT occurs after that cycle.
- RSP:
  - llc_mem_rsp_valid = 1 with llc_mem_rsp_line = buffer; the line is held stable until llc_mem_rsp_ready.
  - On the handshake, go to IDLE and deassert valid the next cycle.
  - A new request is accepted no earlier than the cycle after the return to IDLE.
- Latency with mem_ready tied high:
  - Write: WORDS_PER_LINE cycles after acceptance.
  - Read: 2 cycles per beat plus memory read latency, then RSP.
- Beat counter: BEAT_BITS wide, and it wraps to 0 when leaving the last beat.
- llc_mem_rsp_ready is ignored outside RSP.

Optional Feature:
- Macro: LLC_MEM_WB_FWD_EN.
- Defined:
  - A one-entry forward buffer holds the address and line of the most recent completed write.
  - A read whose address matches a valid entry goes from IDLE straight to RSP with the buffered line and issues no memory beats.
  - The entry is invalidated by reset.
  - Each later completed write overwrites the entry.
- Undefined: every read goes to memory, and no buffer logic exists.

Test Plan:
- Write line 0x10, words {0xA0, 0xA1, 0xA2, 0xA3}, mem_ready = 1 -> 4 beats at mem_addr 0x200, 0x208, 0x210, 0x218 with matching wdata, we = 1; no llc_mem_rsp_valid; req_ready returns 1 after 4 cycles.
- Read line 0x3, memory returns word k = 0x100+k after 2 cycles -> beats at 0x60 to 0x78; llc_mem_rsp_line = {0x103, 0x102, 0x101, 0x100}; one beat outstanding at a time.
- Backpressure: mem_ready low 3 cycles on beat 1 of a write -> mem_addr and mem_wdata held stable; llc_mem_rsp_ready low 5 cycles in RSP -> line held stable; req_ready = 0 throughout.
- Spurious mem_rvalid during IDLE and WR_BEAT -> no state or buffer change.
- Reset asserted in RD_WAIT after beat 2 -> all outputs 0; the next read of line 0x5 completes correctly from beat 0.
- With LLC_MEM_WB_FWD_EN: write line 0x7 then read line 0x7 -> no mem_valid; rsp line equals the written data. Read line 0x8 -> normal memory read.

Source files
------------

// File: rtl/llc_mem_responder.sv
// Memory-side LLC line responder: splits line requests into single-outstanding word beats and reassembles read lines.
// Write retires WORDS_PER_LINE cycles after accept with mem_ready high; a read costs 2 cycles per beat plus memory latency.
// Beat and response outputs hold while mem_ready / llc_mem_rsp_ready are low. `LLC_MEM_WB_FWD_EN adds a last-write forward buffer.
module llc_mem_responder #(
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_BITS      = 64,
    parameter int LINE_ADDR_BITS = 27,
    parameter int HPROT_BITS     = 2,
    localparam int BEAT_BITS     = $clog2(WORDS_PER_LINE),
    localparam int OFF_BITS      = $clog2(WORD_BITS / 8),
    localparam int ADDR_BITS     = LINE_ADDR_BITS + BEAT_BITS + OFF_BITS,
    localparam int LINE_BITS     = WORDS_PER_LINE * WORD_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      llc_mem_req_valid,
    output logic                      llc_mem_req_ready,
    input  logic                      llc_mem_req_hwrite,
    input  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr,
    input  logic [HPROT_BITS-1:0]     llc_mem_req_hprot,
    input  logic [LINE_BITS-1:0]      llc_mem_req_line,
    output logic                      llc_mem_rsp_valid,
    input  logic                      llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0]      llc_mem_rsp_line,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic [ADDR_BITS-1:0]      mem_addr,
    output logic [WORD_BITS-1:0]      mem_wdata,
    output logic [HPROT_BITS-1:0]     mem_hprot,
    input  logic                      mem_rvalid,
    input  logic [WORD_BITS-1:0]      mem_rdata
);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, WR_BEAT, RD_BEAT, RD_WAIT, RSP} state_t;

    state_t                    state;
    logic [BEAT_BITS-1:0]      beat;
    logic [LINE_ADDR_BITS-1:0] addr_q;
    logic [HPROT_BITS-1:0]     hprot_q;
    logic [LINE_BITS-1:0]      line_q;
    logic                      fwd_hit;

`ifdef LLC_MEM_WB_FWD_EN
    logic                      fwd_vld;
    logic [LINE_ADDR_BITS-1:0] fwd_addr;
    logic [LINE_BITS-1:0]      fwd_line;

    assign fwd_hit = fwd_vld && !llc_mem_req_hwrite && (fwd_addr == llc_mem_req_addr);
`else
    assign fwd_hit = 1'b0;
`endif

    // One line buffer serves as write source and read assembly area.
    assign mem_addr         = {addr_q, beat, {OFF_BITS{1'b0}}};
    assign mem_wdata        = line_q[int'(beat) * WORD_BITS +: WORD_BITS];
    assign mem_hprot        = mem_valid ? hprot_q : '0;
    assign llc_mem_rsp_line = line_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            beat              <= '0;
            addr_q            <= '0;
            hprot_q           <= '0;
            line_q            <= '0;
            llc_mem_req_ready <= 1'b0;
            llc_mem_rsp_valid <= 1'b0;
            mem_valid         <= 1'b0;
            mem_we            <= 1'b0;
`ifdef LLC_MEM_WB_FWD_EN
            fwd_vld           <= 1'b0;
            fwd_addr          <= '0;
            fwd_line          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (llc_mem_req_valid && llc_mem_req_ready) begin
                        addr_q            <= llc_mem_req_addr;
                        hprot_q           <= llc_mem_req_hprot;
                        line_q            <= llc_mem_req_line;
                        beat              <= '0;
                        llc_mem_req_ready <= 1'b0;
                        if (fwd_hit) begin
`ifdef LLC_MEM_WB_FWD_EN
                            line_q <= fwd_line;
`endif
                            llc_mem_rsp_valid <= 1'b1;
                            state             <= RSP;
                        end else if (llc_mem_req_hwrite) begin
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b1;
                            state     <= WR_BEAT;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            state     <= RD_BEAT;
                        end
                    end else begin
                        llc_mem_req_ready <= 1'b1;
                    end
                end
                WR_BEAT: begin
                    if (mem_ready) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            mem_valid         <= 1'b0;
                            mem_we            <= 1'b0;
                            llc_mem_req_ready <= 1'b1;
                            state             <= IDLE;
`ifdef LLC_MEM_WB_FWD_EN
                            fwd_vld  <= 1'b1;
                            fwd_addr <= addr_q;
                            fwd_line <= line_q;
`endif
                        end
                    end
                end
                RD_BEAT: begin
                    // Dropping valid right after the handshake keeps one read in flight.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        line_q[int'(beat) * WORD_BITS +: WORD_BITS] <= mem_rdata;
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            llc_mem_rsp_valid <= 1'b1;
                            state             <= RSP;
                        end else begin
                            mem_valid <= 1'b1;
                            state     <= RD_BEAT;
                        end
                    end
                end
                RSP: begin
                    if (llc_mem_rsp_ready) begin
                        llc_mem_rsp_valid <= 1'b0;
                        llc_mem_req_ready <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_mem_responder.sv
// Directed plus randomized bench for llc_mem_responder against a line-level memory model.
module tb_llc_mem_responder;
    localparam int WPL = 4;
    localparam int WB  = 64;
    localparam int LAB = 27;
    localparam int HB  = 2;
    localparam int AB  = LAB + 2 + 3;
    localparam int LB  = WPL * WB;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           llc_mem_req_valid = 1'b0;
    logic           llc_mem_req_ready;
    logic           llc_mem_req_hwrite = 1'b0;
    logic [LAB-1:0] llc_mem_req_addr = '0;
    logic [HB-1:0]  llc_mem_req_hprot = '0;
    logic [LB-1:0]  llc_mem_req_line = '0;
    logic           llc_mem_rsp_valid;
    logic           llc_mem_rsp_ready = 1'b0;
    logic [LB-1:0]  llc_mem_rsp_line;
    logic           mem_valid;
    logic           mem_ready = 1'b0;
    logic           mem_we;
    logic [AB-1:0]  mem_addr;
    logic [WB-1:0]  mem_wdata;
    logic [HB-1:0]  mem_hprot;
    logic           mem_rvalid = 1'b0;
    logic [WB-1:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    llc_mem_responder dut (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
        .llc_mem_req_hwrite(llc_mem_req_hwrite), .llc_mem_req_addr(llc_mem_req_addr),
        .llc_mem_req_hprot(llc_mem_req_hprot), .llc_mem_req_line(llc_mem_req_line),
        .llc_mem_rsp_valid(llc_mem_rsp_valid), .llc_mem_rsp_ready(llc_mem_rsp_ready),
        .llc_mem_rsp_line(llc_mem_rsp_line),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_hprot(mem_hprot), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [WB-1:0] wdata;
        logic [HB-1:0] hprot;
    } beat_t;

    beat_t         beat_q[$];
    logic [WB-1:0] mem_store[logic [AB-1:0]];
    logic [LB-1:0] ref_lines[int];
    bit            last_wr_vld = 1'b0;
    int            last_wr_line = 0;

    int            rd_lat = 2;
    bit            rdy_force = 1'b1;
    int            stall_cnt = 0;
    bit            spur = 1'b0;
    bit            rd_pend = 1'b0;
    int            rd_cnt = 0;
    logic [AB-1:0] rd_addr = '0;
    bit            p_vld = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
    logic [AB-1:0] p_addr = '0;
    logic [WB-1:0] p_wdata = '0;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AB-1:0] beat_addr(input int ln, input int k);
        return AB'(ln * (WPL * WB / 8) + k * (WB / 8));
    endfunction

    function automatic logic [WB-1:0] dflt_word(input logic [AB-1:0] a);
        return {32'hC0DE_0000 ^ 32'(a), 32'(a)};
    endfunction

    function automatic logic [LB-1:0] exp_line(input int ln);
        logic [LB-1:0] r;
        if (ref_lines.exists(ln)) return ref_lines[ln];
        for (int k = 0; k < WPL; k++) r[k*WB +: WB] = dflt_word(beat_addr(ln, k));
        return r;
    endfunction

    // Memory model: samples handshakes on the edge, drives its outputs 1 time unit later.
    always begin
        @(posedge clk);
        if (!rst) begin
            rd_pend = 1'b0;
            p_vld   = 1'b0;
        end else begin
            if (p_vld && !p_rdy) begin
                chk("hold_valid", mem_valid, 1'b1);
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_wdata", mem_wdata, p_wdata);
                chk("hold_we", mem_we, p_we);
            end
            if (rd_pend) chk("one_outstanding", mem_valid, 1'b0);
            if (mem_valid && mem_ready) begin
                beat_q.push_back('{mem_we, mem_addr, mem_wdata, mem_hprot});
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                else begin
                    rd_pend = 1'b1;
                    rd_cnt  = rd_lat;
                    rd_addr = mem_addr;
                end
            end
            p_vld = mem_valid; p_rdy = mem_ready; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
        end
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt <= 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_store.exists(rd_addr) ? mem_store[rd_addr] : dflt_word(rd_addr);
                rd_pend    = 1'b0;
            end
        end else if (spur) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
        end
        if (stall_cnt > 0 && mem_valid && mem_we && ((mem_addr / 8) % WPL) == 1) begin
            mem_ready = 1'b0;
            stall_cnt--;
        end else begin
            mem_ready = rdy_force ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, llc_mem_req_ready, 1'b0);
        chk({tag, "_rsp_valid"}, llc_mem_rsp_valid, 1'b0);
        chk({tag, "_rsp_line"}, llc_mem_rsp_line, '0);
        chk({tag, "_mem_valid"}, mem_valid, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_mem_hprot"}, mem_hprot, '0);
    endtask

    task automatic send_req(input bit we, input int ln, input logic [LB-1:0] d, input logic [HB-1:0] hp);
        int n = 0;
        while (llc_mem_req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("req_ready_before_issue", llc_mem_req_ready, 1'b1);
        llc_mem_req_valid  = 1'b1;
        llc_mem_req_hwrite = we;
        llc_mem_req_addr   = LAB'(ln);
        llc_mem_req_hprot  = hp;
        llc_mem_req_line   = d;
        @(posedge clk); #1;
        llc_mem_req_valid  = 1'b0;
        llc_mem_req_line   = {LB/32{$urandom}};
        chk("req_ready_low_after_accept", llc_mem_req_ready, 1'b0);
    endtask

    task automatic do_write(input int ln, input logic [LB-1:0] d, input logic [HB-1:0] hp, input bit chk_lat);
        int n = 0;
        beat_q.delete();
        send_req(1'b1, ln, d, hp);
        while (llc_mem_req_ready !== 1'b1 && n < 200) begin
            chk("wr_no_rsp", llc_mem_rsp_valid, 1'b0);
            @(posedge clk); #1; n++;
        end
        chk("wr_done_ready", llc_mem_req_ready, 1'b1);
        if (chk_lat) chk("wr_latency", n, WPL);
        chk("wr_beat_count", beat_q.size(), WPL);
        for (int k = 0; k < beat_q.size() && k < WPL; k++) begin
            chk("wr_beat_addr", beat_q[k].addr, beat_addr(ln, k));
            chk("wr_beat_wdata", beat_q[k].wdata, d[k*WB +: WB]);
            chk("wr_beat_we", beat_q[k].we, 1'b1);
            chk("wr_beat_hprot", beat_q[k].hprot, hp);
        end
        ref_lines[ln] = d;
        last_wr_vld   = 1'b1;
        last_wr_line  = ln;
    endtask

    task automatic do_read(input int ln, input logic [HB-1:0] hp, input int rsp_stall, input bit pre_rdy);
        int n = 0;
        bit hit;
        logic [LB-1:0] exp = exp_line(ln);
`ifdef LLC_MEM_WB_FWD_EN
        hit = last_wr_vld && last_wr_line == ln;
`else
        hit = 1'b0;
`endif
        beat_q.delete();
        llc_mem_rsp_ready = pre_rdy;
        send_req(1'b0, ln, {LB/32{$urandom}}, hp);
        if (!pre_rdy) llc_mem_rsp_ready = 1'b0;
        while (llc_mem_rsp_valid !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
        chk("rd_rsp_valid", llc_mem_rsp_valid, 1'b1);
        for (int s = 0; s < rsp_stall; s++) begin
            chk("rsp_stall_line", llc_mem_rsp_line, exp);
            chk("rsp_stall_valid", llc_mem_rsp_valid, 1'b1);
            chk("rsp_stall_req_ready", llc_mem_req_ready, 1'b0);
            @(posedge clk); #1;
        end
        chk("rd_rsp_line", llc_mem_rsp_line, exp);
        llc_mem_rsp_ready = 1'b1;
        @(posedge clk); #1;
        llc_mem_rsp_ready = 1'b0;
        chk("rsp_valid_drop", llc_mem_rsp_valid, 1'b0);
        chk("rd_beat_count", beat_q.size(), hit ? 0 : WPL);
        for (int k = 0; k < beat_q.size() && k < WPL; k++) begin
            chk("rd_beat_addr", beat_q[k].addr, beat_addr(ln, k));
            chk("rd_beat_we", beat_q[k].we, 1'b0);
            chk("rd_beat_hprot", beat_q[k].hprot, hp);
        end
    endtask

    initial begin
        logic [LB-1:0] d;
        int n;

        for (int k = 0; k < WPL; k++) begin
            mem_store[beat_addr(3, k)] = 64'h100 + 64'(k);
            d[k*WB +: WB] = 64'h100 + 64'(k);
        end
        ref_lines[3] = d;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", llc_mem_req_ready, 1'b1);

        // Basic write and read
        do_write(16, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 2'd2, 1'b1);
        chk("idle_hprot", mem_hprot, '0);
        rd_lat = 2;
        do_read(3, 2'd1, 0, 1'b0);

        // Backpressure on write beat 1 and on the response
        stall_cnt = 3;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(18, d, 2'd3, 1'b0);
        chk("stall_consumed", stall_cnt, 0);
        do_read(18, 2'd0, 5, 1'b0);

        // Spurious rvalid in IDLE and during a write
        spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("spur_idle_ready", llc_mem_req_ready, 1'b1);
            chk("spur_idle_valid", mem_valid, 1'b0);
        end
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(17, d, 2'd1, 1'b1);
        spur = 1'b0;
        do_read(17, 2'd2, 0, 1'b0);

        // Reset while waiting on beat 2 of a read
        beat_q.delete();
        send_req(1'b0, 5, '0, 2'd1);
        n = 0;
        while (beat_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
        chk("midreset_beats_issued", beat_q.size(), 3);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (3) begin @(posedge clk); #1; chk("midreset_no_rsp", llc_mem_rsp_valid, 1'b0); end
        rst = 1'b1;
        last_wr_vld = 1'b0;
        do_read(5, 2'd3, 0, 1'b0);

        // Forward path (memory-only build expects normal beats)
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(7, d, 2'd0, 1'b1);
        do_read(7, 2'd1, 0, 1'b0);
        do_read(8, 2'd1, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            int ln = 32 + $urandom_range(0, 5);
            rdy_force = $urandom_range(0, 1);
            rd_lat = $urandom_range(1, 3);
            if ($urandom_range(0, 1)) begin
                d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                do_write(ln, d, HB'($urandom), rdy_force);
            end else begin
                do_read(ln, HB'($urandom), $urandom_range(0, 2), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
